// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the staged reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        RELEASE,
        RUN
    } rseq_state_t;

    // Bits needed to hold 0..max_count; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/request inputs and staged reset outputs of the sequencer
interface reset_sequencer_if #(
    parameter int N_STAGES = 3
);
    logic                lock_in;
    logic                sw_reset;
    logic [N_STAGES-1:0] rst_out;
    logic [N_STAGES-1:0] rstn_out;
    logic                done;
    logic                timeout;

    modport master (
        input  lock_in,
        input  sw_reset,
        output rst_out,
        output rstn_out,
        output done,
        output timeout
    );

    modport slave (
        output lock_in,
        output sw_reset,
        input  rst_out,
        input  rstn_out,
        input  done,
        input  timeout
    );
endinterface

// File: rtl/reset_sequencer_lock_filter.sv
// rtl/reset_sequencer_lock_filter.sv - consecutive-high counter qualifying the lock indication
module lock_filter
    import reset_seq_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in,
    output logic stable
);
    localparam int             W    = cnt_width(FILTER_LEN);
    localparam logic [W-1:0]   LAST = W'(FILTER_LEN - 1);
    localparam logic [W-1:0]   FULL = W'(FILTER_LEN);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr || !in) begin
            cnt <= '0;
        end else if (cnt != FULL) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Flags the edge on which the count reaches FILTER_LEN so the sequencer acts on that same edge.
    assign stable = !clr && in && (cnt >= LAST);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release gated by minimum hold time and filtered clock lock
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES     = 3,
    parameter int MIN_ASSERT   = 64,
    parameter int FILTER_LEN   = 4,
    parameter int STAGE_DELAY  = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.master rs
);
    localparam int HW     = cnt_width(MIN_ASSERT - 1);
    localparam int GW     = cnt_width(STAGE_DELAY - 1);
    localparam int TO_MAX = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT : 1;
    localparam int TW     = cnt_width(TO_MAX);
    localparam int IW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam bit TO_EN  = (LOCK_TIMEOUT > 0);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_ASSERT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_DELAY - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_MAX - 1);
    localparam logic [TW-1:0] TO_FULL   = TW'(TO_MAX);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

    if (N_STAGES < 1) begin : g_bad_stages
        $error("reset_sequencer: N_STAGES must be >= 1");
    end
    if (MIN_ASSERT < 1) begin : g_bad_assert
        $error("reset_sequencer: MIN_ASSERT must be >= 1");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("reset_sequencer: FILTER_LEN must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_delay
        $error("reset_sequencer: STAGE_DELAY must be >= 1");
    end
    if (LOCK_TIMEOUT < 0) begin : g_bad_timeout
        $error("reset_sequencer: LOCK_TIMEOUT must be >= 0");
    end

    rseq_state_t   state;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic [IW-1:0] idx;
    logic          lock_stable;
    logic          abort;

    lock_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_lock_filter (
        .clk    (clk),
        .reset  (reset),
        .clr    (state != WAIT_LOCK),
        .in     (rs.lock_in),
        .stable (lock_stable)
    );

    // WAIT_LOCK tolerates a low lock (it only restarts the filter); later states treat it as loss.
    always_comb begin
        abort = 1'b0;
        case (state)
            WAIT_LOCK:   abort = rs.sw_reset;
            RELEASE,
            RUN:         abort = rs.sw_reset || !rs.lock_in;
            default:     abort = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            idx         <= '0;
            rs.rst_out  <= '1;
            rs.rstn_out <= '0;
            rs.done     <= 1'b0;
            rs.timeout  <= 1'b0;
        end else if (abort) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            idx         <= '0;
            rs.rst_out  <= '1;
            rs.rstn_out <= '0;
            rs.done     <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (rs.sw_reset) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= WAIT_LOCK;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (TO_EN && to_cnt == TO_LAST) begin
                        rs.timeout <= 1'b1;
                    end
                    if (to_cnt != TO_FULL) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (lock_stable) begin
                        to_cnt         <= '0;
                        gap_cnt        <= '0;
                        rs.rst_out[0]  <= 1'b0;
                        rs.rstn_out[0] <= 1'b1;
                        if (N_STAGES == 1) begin
                            rs.done <= 1'b1;
                            state   <= RUN;
                        end else begin
                            idx   <= IW'(1);
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt          <= '0;
                        rs.rst_out[idx]  <= 1'b0;
                        rs.rstn_out[idx] <= 1'b1;
                        if (idx == IDX_LAST) begin
                            rs.done <= 1'b1;
                            state   <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reset_sequencer_if #(.N_STAGES(3)) rs_if ();

    reset_sequencer #(
        .N_STAGES     (3),
        .MIN_ASSERT   (8),
        .FILTER_LEN   (4),
        .STAGE_DELAY  (4),
        .LOCK_TIMEOUT (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rs    (rs_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] exp_rst,
                           input logic exp_done, input logic exp_to);
        logic [2:0] exp_rstn;
        exp_rstn = ~exp_rst;
        chk({tag, ".rst_out"},  {29'd0, rs_if.rst_out},  {29'd0, exp_rst});
        chk({tag, ".rstn_out"}, {29'd0, rs_if.rstn_out}, {29'd0, exp_rstn});
        chk({tag, ".done"},     {31'd0, rs_if.done},     {31'd0, exp_done});
        chk({tag, ".timeout"},  {31'd0, rs_if.timeout},  {31'd0, exp_to});
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        rs_if.lock_in   = 1'b1;
        rs_if.sw_reset  = 1'b0;

        tick(3);
        chk_out("reset", 3'b111, 1'b0, 1'b0);

        // Nominal: release at E0; stages fall after E11, E15, E19.
        reset = 1'b0;
        tick(11);
        chk_out("nom_e10", 3'b111, 1'b0, 1'b0);
        tick(1);
        chk_out("nom_e11", 3'b110, 1'b0, 1'b0);
        tick(3);
        chk_out("nom_e14", 3'b110, 1'b0, 1'b0);
        tick(1);
        chk_out("nom_e15", 3'b100, 1'b0, 1'b0);
        tick(3);
        chk_out("nom_e18", 3'b100, 1'b0, 1'b0);
        tick(1);
        chk_out("nom_e19", 3'b000, 1'b1, 1'b0);
        tick(5);
        chk_out("nom_run", 3'b000, 1'b1, 1'b0);

        // Lock loss in RUN: one low cycle aborts, then the full sequence repeats.
        rs_if.lock_in = 1'b0;
        tick(1);
        chk_out("loss_abort", 3'b111, 1'b0, 1'b0);
        rs_if.lock_in = 1'b1;
        tick(11);
        chk_out("loss_e11", 3'b111, 1'b0, 1'b0);
        tick(1);
        chk_out("loss_e12", 3'b110, 1'b0, 1'b0);
        tick(4);
        chk_out("loss_e16", 3'b100, 1'b0, 1'b0);
        tick(4);
        chk_out("loss_e20", 3'b000, 1'b1, 1'b0);

        // Lock glitch in WAIT_LOCK after two good samples delays release by 3 cycles.
        rs_if.sw_reset = 1'b1;
        tick(1);
        chk_out("glitch_abort", 3'b111, 1'b0, 1'b0);
        rs_if.sw_reset = 1'b0;
        tick(10);
        rs_if.lock_in = 1'b0;
        tick(1);
        chk_out("glitch_low", 3'b111, 1'b0, 1'b0);
        rs_if.lock_in = 1'b1;
        tick(3);
        chk_out("glitch_e13", 3'b111, 1'b0, 1'b0);
        tick(1);
        chk_out("glitch_e14", 3'b110, 1'b0, 1'b0);
        tick(8);
        chk_out("glitch_done", 3'b000, 1'b1, 1'b0);

        // sw_reset pulse during RELEASE with rst_out=110.
        rs_if.sw_reset = 1'b1;
        tick(1);
        rs_if.sw_reset = 1'b0;
        tick(12);
        chk_out("sw_rel", 3'b110, 1'b0, 1'b0);
        rs_if.sw_reset = 1'b1;
        tick(1);
        chk_out("sw_abort", 3'b111, 1'b0, 1'b0);
        rs_if.sw_reset = 1'b0;
        tick(11);
        chk_out("sw_hold", 3'b111, 1'b0, 1'b0);
        tick(1);
        chk_out("sw_again", 3'b110, 1'b0, 1'b0);
        tick(8);
        chk_out("sw_done", 3'b000, 1'b1, 1'b0);

        // Timeout: lock stays low; flag sets at the 32nd edge after WAIT_LOCK entry.
        rs_if.lock_in = 1'b0;
        tick(1);
        chk_out("to_abort", 3'b111, 1'b0, 1'b0);
        tick(39);
        chk_out("to_before", 3'b111, 1'b0, 1'b0);
        tick(1);
        chk_out("to_set", 3'b111, 1'b0, 1'b1);
        tick(5);
        chk_out("to_sticky", 3'b111, 1'b0, 1'b1);
        rs_if.lock_in = 1'b1;
        tick(3);
        chk_out("to_filter", 3'b111, 1'b0, 1'b1);
        tick(1);
        chk_out("to_rel0", 3'b110, 1'b0, 1'b1);
        tick(8);
        chk_out("to_done", 3'b000, 1'b1, 1'b1);

        // reset mid-RELEASE restores every reset value including timeout.
        rs_if.sw_reset = 1'b1;
        tick(1);
        rs_if.sw_reset = 1'b0;
        tick(14);
        chk_out("rst_mid_pre", 3'b110, 1'b0, 1'b1);
        reset = 1'b1;
        tick(1);
        chk_out("rst_mid", 3'b111, 1'b0, 1'b0);
        reset = 1'b0;
        tick(12);
        chk_out("rst_mid_e11", 3'b110, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
